ula_seq_divider: RTL

ULA_SEQ_DIVIDER -- requirements
Module: ula_seq_divider

---
 rtl/ula_div_pkg.sv | 18 +
 rtl/ula_div_step.sv | 22 ++
 rtl/ula_seq_divider.sv | 115 +++++++++++
 3 files changed

// File: rtl/ula_div_pkg.sv
// Shared types and constants for the sequential 8-bit divider.
// Also holds get_absolute_value, the conditional two's-complement negate used for magnitudes and sign fix-up.
package ula_div_pkg;

  localparam int DIV_W    = 8;
  localparam int RES_W    = 16;
  localparam int ITER_CNT = 8;
  localparam int CNT_W    = $clog2(ITER_CNT);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} div_state_e;

  // Returns -val when neg is set, val otherwise. Note that -8'h80 wraps back to 8'h80.
  function automatic logic [DIV_W-1:0] get_absolute_value(input logic [DIV_W-1:0] val,
                                                          input logic             neg);
    return neg ? DIV_W'(~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/ula_div_step.sv
// One restoring-division step. The partial remainder is shifted left and the next dividend bit is brought in.
// If the divisor fits, it is subtracted and the quotient bit is set; otherwise the shifted value is kept.
module ula_div_step
  import ula_div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_out,
  output logic             q_bit
);

  logic [DIV_W:0] shifted;

  always_comb begin
    shifted = {rem_in, dvd_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    // The remainder is always below the divisor, so 8 bits are enough after the subtract.
    rem_out = q_bit ? DIV_W'(shifted - {1'b0, divisor}) : shifted[DIV_W-1:0];
  end

endmodule

// File: rtl/ula_seq_divider.sv
// Sequential 8-bit restoring divider: IDLE -> CALC (8 steps) -> FINISH. Result is {remainder, quotient}.
// Define ULA_DIV_SIGNED_EN to get two's-complement operands (truncating); the default build is unsigned.
module ula_seq_divider
  import ula_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] a,
  input  logic [DIV_W-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             sign_flag,
  output logic             zero_flag,
  output logic             div_zero_flag
);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] rem_q, dvd_q, dsr_q;
  logic             dz_q;
  logic [DIV_W-1:0] a_mag, b_mag, quo_fin, rem_fin, step_rem;
  logic             step_q, sign_res;

`ifdef ULA_DIV_SIGNED_EN
  logic sa_q, sb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else if (state == IDLE && start) begin
      sa_q <= a[DIV_W-1];
      sb_q <= b[DIV_W-1];
    end
  end

  assign a_mag    = get_absolute_value(a, a[DIV_W-1]);
  assign b_mag    = get_absolute_value(b, b[DIV_W-1]);
  // The quotient takes the XOR of the operand signs. The remainder follows the dividend.
  assign quo_fin  = get_absolute_value(dvd_q, sa_q ^ sb_q);
  assign rem_fin  = get_absolute_value(rem_q, sa_q);
  assign sign_res = quo_fin[DIV_W-1];
`else
  assign a_mag    = a;
  assign b_mag    = b;
  assign quo_fin  = dvd_q;
  assign rem_fin  = rem_q;
  assign sign_res = 1'b0;
`endif

  ula_div_step u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[DIV_W-1]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // The dividend register shifts out dividend bits at the top and shifts in quotient bits at the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rem_q         <= '0;
      dvd_q         <= '0;
      dsr_q         <= '0;
      dz_q          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      sign_flag     <= 1'b0;
      zero_flag     <= 1'b0;
      div_zero_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rem_q <= '0;
          dvd_q <= a_mag;
          dsr_q <= b_mag;
          dz_q  <= (b == '0);
          cnt   <= '0;
          busy  <= 1'b1;
          state <= (b == '0) ? FINISH : CALC;
        end
        CALC: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[DIV_W-2:0], step_q};
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER_CNT - 1)) state <= FINISH;
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          if (dz_q) begin
            result        <= '0;
            sign_flag     <= 1'b0;
            zero_flag     <= 1'b1;
            div_zero_flag <= 1'b1;
          end else begin
            result        <= {rem_fin, quo_fin};
            sign_flag     <= sign_res;
            zero_flag     <= (quo_fin == '0);
            div_zero_flag <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
